// File: rtl/ssc_change_dispenser_if.sv
// Result/coin channel bundle for the snack-shop change dispenser.
// slave  : the dispenser view (takes the result, drives coin requests and status).
// master : the surrounding view (SSC result stage + coin hopper).
// Ports  : in_valid/in_ready/in_card_ok/in_change (result handshake),
//          coin_valid/coin_ready/coin_code/coin_value (coin handshake),
//          is_refund/done (transaction status).
interface ssc_change_dispenser_if #(
  parameter int W_CHG = 9
);
  logic             in_valid;
  logic             in_ready;
  logic             in_card_ok;
  logic [W_CHG-1:0] in_change;
  logic             coin_valid;
  logic             coin_ready;
  logic [1:0]       coin_code;
  logic [5:0]       coin_value;
  logic             is_refund;
  logic             done;

  modport slave (
    input  in_valid, in_card_ok, in_change, coin_ready,
    output in_ready, coin_valid, coin_code, coin_value, is_refund, done
  );

  modport master (
    output in_valid, in_card_ok, in_change, coin_ready,
    input  in_ready, coin_valid, coin_code, coin_value, is_refund, done
  );
endinterface

// File: rtl/ssc_change_dispenser.sv
// Change dispenser: accepts one (card_ok, change) result and pays it out as
// coins, greedy largest-first, one coin per coin handshake.
// Latency: done pulses ncoins+1 cycles after acceptance when coin_ready is high;
// a low coin_ready holds the current coin request stable until accepted.
// Ports: clk, rst (synchronous, active-high), bus (slave modport of
// ssc_change_dispenser_if). Optional: SSC_DISP_STATS_EN adds coin_total and
// txn_total saturating 16-bit counters of coin handshakes and done pulses.
module ssc_change_dispenser #(
  parameter int W_CHG  = 9,
  parameter int DENOM0 = 50,
  parameter int DENOM1 = 10,
  parameter int DENOM2 = 5,
  parameter int DENOM3 = 1   // must be 1 so every amount can be paid
) (
  input  logic                   clk,
  input  logic                   rst,
  ssc_change_dispenser_if.slave  bus
`ifdef SSC_DISP_STATS_EN
  ,
  output logic [15:0]            coin_total,
  output logic [15:0]            txn_total
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [W_CHG-1:0] rem, rem_nxt;
  logic [1:0]       code_q, code_nxt;
  logic [5:0]       val_q, val_nxt;
  logic             refund_q, refund_nxt;
  logic [W_CHG-1:0] rem_after;

  // Largest denomination not exceeding amt. Only called with amt != 0, so
  // the DENOM3 fall-through is always a legal coin.
  function automatic logic [1:0] pick(input logic [W_CHG-1:0] amt);
    if (amt >= W_CHG'(DENOM0))      return 2'd0;
    else if (amt >= W_CHG'(DENOM1)) return 2'd1;
    else if (amt >= W_CHG'(DENOM2)) return 2'd2;
    else                            return 2'd3;
  endfunction

  function automatic logic [5:0] denom_of(input logic [1:0] code);
    case (code)
      2'd0:    return 6'(DENOM0);
      2'd1:    return 6'(DENOM1);
      2'd2:    return 6'(DENOM2);
      default: return 6'(DENOM3);
    endcase
  endfunction

  // The coin being offered never exceeds rem, so this cannot underflow.
  assign rem_after = rem - W_CHG'(val_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      code_q   <= 2'd0;
      val_q    <= 6'd0;
      refund_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      code_q   <= code_nxt;
      val_q    <= val_nxt;
      refund_q <= refund_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    code_nxt   = code_q;
    val_nxt    = val_q;
    refund_nxt = refund_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          rem_nxt    = bus.in_change;
          refund_nxt = ~bus.in_card_ok;
          if (bus.in_change != '0) begin
            state_nxt = DISP;
            code_nxt  = pick(bus.in_change);
            val_nxt   = denom_of(pick(bus.in_change));
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DISP: begin
        // coin_valid is implied by DISP; only coin_ready gates progress,
        // so code/value are untouched while the hopper stalls.
        if (bus.coin_ready) begin
          rem_nxt = rem_after;
          if (rem_after == '0) begin
            state_nxt = DONE;
          end else begin
            code_nxt = pick(rem_after);
            val_nxt  = denom_of(pick(rem_after));
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode the state register directly, so they are glitch-free.
  assign bus.in_ready   = (state == IDLE);
  assign bus.coin_valid = (state == DISP);
  assign bus.done       = (state == DONE);
  assign bus.coin_code  = code_q;
  assign bus.coin_value = val_q;
  assign bus.is_refund  = refund_q;

`ifdef SSC_DISP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      coin_total <= 16'd0;
      txn_total  <= 16'd0;
    end else begin
      if (bus.coin_valid && bus.coin_ready && (coin_total != 16'hFFFF))
        coin_total <= coin_total + 16'd1;
      if (bus.done && (txn_total != 16'hFFFF))
        txn_total <= txn_total + 16'd1;
    end
  end
`endif

endmodule
